// File: rtl/board_io_pkg.sv
// Shared definitions for the board input port: register-window addresses,
// bit position of the switch field in STATUS and the press-counter width.
package board_io_pkg;

   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_FLAGS  = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_MASK   = 2'd3;

   localparam int SW_LSB = 8;
   localparam int CNT_W  = 8;

endpackage

// File: rtl/board_input_port_if.sv
// CPU-side register bus of the board input port.
//   master : CPU (drives strobes/addresses/write data, receives read data/irq)
//   slave  : board_input_port
//   rd_en/rd_addr      read strobe and register select
//   rd_data/rd_valid   read result, one cycle after rd_en
//   wr_en/wr_addr/wr_data  write strobe, register select and data
//   irq                masked key-press interrupt request
interface board_input_port_if;

   logic        rd_en;
   logic [1:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic        irq;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data, rd_valid, irq
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data, rd_valid, irq
   );

endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchronizer plus counter-based debouncer for one board input.
//   clock_in  clock, rising edge
//   reset_in  synchronous active-high reset
//   raw_in    asynchronous input, 1 = active
//   level     debounced level
//   rise      high during the cycle whose closing edge flips level 0 -> 1
module input_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock_in,
   input  logic reset_in,
   input  logic raw_in,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_p0;
   logic          sync_p1;
   logic          stable;
   logic [CW-1:0] cnt;

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         stable  <= 1'b0;
         cnt     <= '0;
      end else begin
         // stage p0/p1: metastability synchronizer
         sync_p0 <= raw_in;
         sync_p1 <= sync_p0;
         // debounce: level only follows after DEBOUNCE_CYCLES disagreeing cycles
         if (sync_p1 == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            stable <= ~stable;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign level = stable;
   // Combinational so the register file updates on the same edge the level rises.
   assign rise  = (sync_p1 != stable) && (cnt == LAST) && !stable;

endmodule

// File: rtl/board_input_port.sv
// Debounced memory-mapped input port for the DE10-Nano keys and switches.
//   clock_in  clock, rising edge
//   reset_in  synchronous active-high reset
//   key_n_in  raw push-buttons, 0 = pressed
//   sw_in     raw slide switches, 1 = on
//   bus       register window (slave side): STATUS, FLAGS (W1C), COUNT, MASK, irq
module board_input_port
   import board_io_pkg::*;
#(
   parameter int NUM_KEYS        = 2,
   parameter int NUM_SW          = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clock_in,
   input  logic                reset_in,
   input  logic [NUM_KEYS-1:0] key_n_in,
   input  logic [NUM_SW-1:0]   sw_in,
   board_input_port_if.slave   bus
);

   localparam int NUM_IN = NUM_KEYS + NUM_SW;

   logic [NUM_IN-1:0]              raw_all;
   logic [NUM_IN-1:0]              level_all;
   logic [NUM_IN-1:0]              rise_all;
   logic [NUM_KEYS-1:0]            key_level;
   logic [NUM_KEYS-1:0]            key_rise;
   logic [NUM_SW-1:0]              sw_level;
   logic [NUM_SW-1:0]              sw_rise_unused;
   logic [31:0]                    wr_data_unused;

   logic [NUM_KEYS-1:0]            flags;
   logic [NUM_KEYS-1:0]            mask;
   logic [NUM_KEYS-1:0][CNT_W-1:0] count;
   logic [31:0]                    rd_mux;
   logic                           wr_flags;
   logic                           wr_count;
   logic                           wr_mask;

   // Keys are inverted ahead of the synchronizer so an all-zero chain after
   // reset means "released"; a key held through reset then takes the full
   // debounce time before it registers as a press.
   assign raw_all = {sw_in, ~key_n_in};

   genvar i;
   generate
      for (i = 0; i < NUM_IN; i++) begin : g_deb
         input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_deb (
            .clock_in(clock_in),
            .reset_in(reset_in),
            .raw_in  (raw_all[i]),
            .level   (level_all[i]),
            .rise    (rise_all[i])
         );
      end
   endgenerate

   assign key_level      = level_all[NUM_KEYS-1:0];
   assign key_rise       = rise_all[NUM_KEYS-1:0];
   assign sw_level       = level_all[NUM_IN-1:NUM_KEYS];
   // Switches generate no events; only the key fields of wr_data are stored.
   assign sw_rise_unused = rise_all[NUM_IN-1:NUM_KEYS];
   assign wr_data_unused = bus.wr_data;

   assign wr_flags = bus.wr_en && (bus.wr_addr == ADDR_FLAGS);
   assign wr_count = bus.wr_en && (bus.wr_addr == ADDR_COUNT);
   assign wr_mask  = bus.wr_en && (bus.wr_addr == ADDR_MASK);

   always_comb begin
      rd_mux = '0;
      case (bus.rd_addr)
         ADDR_STATUS: begin
            rd_mux[NUM_KEYS-1:0]      = key_level;
            rd_mux[SW_LSB +: NUM_SW]  = sw_level;
         end
         ADDR_FLAGS: rd_mux[NUM_KEYS-1:0] = flags;
         ADDR_COUNT: begin
            for (int k = 0; k < NUM_KEYS; k++) begin
               rd_mux[k*CNT_W +: CNT_W] = count[k];
            end
         end
         ADDR_MASK:  rd_mux[NUM_KEYS-1:0] = mask;
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clock_in) begin
      if (reset_in) begin
         flags        <= '0;
         count        <= '0;
         mask         <= '0;
         bus.irq      <= 1'b0;
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_KEYS; k++) begin
            // A press on the same edge as a W1C keeps the flag set.
            if (key_rise[k]) begin
               flags[k] <= 1'b1;
            end else if (wr_flags && bus.wr_data[k]) begin
               flags[k] <= 1'b0;
            end
            // A COUNT write beats a simultaneous press.
            if (wr_count) begin
               count[k] <= '0;
            end else if (key_rise[k]) begin
               count[k] <= count[k] + CNT_W'(1);
            end
         end
         if (wr_mask) begin
            mask <= bus.wr_data[NUM_KEYS-1:0];
         end
         // stage p1: irq and read data registered from pre-edge register state
         bus.irq      <= |(flags & mask);
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            bus.rd_data <= rd_mux;
         end
      end
   end

endmodule
